// File: rtl/plab4_net_router_input_queue_pkg.sv
// Shared ring-network message layout for the router input queue: field offsets,
// dest-width derivation and a DEST slicing macro.
`ifndef PLAB4_NET_ROUTER_INPUT_QUEUE_PKG_SV
`define PLAB4_NET_ROUTER_INPUT_QUEUE_PKG_SV

// Slices the dest field (the MSBs) out of a net message of any width.
`define PLAB4_NET_DEST(msg_, nbits_) msg_[$bits(msg_)-1 -: (nbits_)]

package plab4_net_router_input_queue_pkg;

    localparam int unsigned c_net_num_routers = 8;
    localparam int unsigned c_net_msg_nbits   = 44;

    // Dest width never collapses to zero, even for a single-router ring.
    function automatic int unsigned net_dest_nbits(input int unsigned num_routers);
        return (num_routers <= 1) ? 1 : $clog2(num_routers);
    endfunction

    localparam int unsigned c_net_dest_nbits   = net_dest_nbits(c_net_num_routers);

    localparam int unsigned c_net_dest_msb     = c_net_msg_nbits - 1;
    localparam int unsigned c_net_dest_lsb     = c_net_msg_nbits - c_net_dest_nbits;
    localparam int unsigned c_net_src_msb      = c_net_dest_lsb - 1;
    localparam int unsigned c_net_src_lsb      = c_net_dest_lsb - c_net_dest_nbits;
    localparam int unsigned c_net_opaque_msb   = c_net_src_lsb - 1;
    localparam int unsigned c_net_opaque_lsb   = 32;
    localparam int unsigned c_net_payload_msb  = 31;
    localparam int unsigned c_net_payload_lsb  = 0;

    typedef struct packed {
        logic [c_net_dest_nbits-1:0]                       dest;
        logic [c_net_dest_nbits-1:0]                       src;
        logic [c_net_opaque_msb-c_net_opaque_lsb:0]         opaque;
        logic [c_net_payload_msb-c_net_payload_lsb:0]       payload;
    } net_msg_t;

endpackage

`endif

// File: rtl/plab4_net_router_input_queue_ctrl.sv
// Input queue control: pointers, occupancy, handshake signals, bypass select and
// the registered free-entry count. Bypass is built with PLAB4_NET_INPUT_QUEUE_BYPASS_EN.
module plab4_net_router_input_queue_ctrl #(
    parameter int p_num_entries    = 4,
    parameter int p_num_free_nbits = 3,
    parameter int c_addr_nbits     = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        i_enq_val,
    input  logic                        i_deq_rdy,
    output logic                        o_enq_rdy,
    output logic                        o_deq_val,
    output logic                        o_wr_en,
    output logic                        o_bypass_sel,
    output logic [c_addr_nbits-1:0]     o_wr_ptr,
    output logic [c_addr_nbits-1:0]     o_rd_ptr,
    output logic [p_num_free_nbits-1:0] o_num_free
);

    localparam int c_cnt_nbits = c_addr_nbits + 1;
    localparam logic [c_cnt_nbits-1:0]      c_full      = c_cnt_nbits'(p_num_entries);
    localparam logic [p_num_free_nbits-1:0] c_free_init = p_num_free_nbits'(p_num_entries);

    logic [c_addr_nbits-1:0]     r_wr_ptr;
    logic [c_addr_nbits-1:0]     r_rd_ptr;
    logic [c_cnt_nbits-1:0]      r_count;
    logic [p_num_free_nbits-1:0] r_num_free;

    logic                        w_empty;
    logic                        w_bypass;
    logic                        w_enq_fire;
    logic                        w_deq_fire;
    logic                        w_wr_en;
    logic                        w_rd_adv;
    logic [c_cnt_nbits-1:0]      w_count_next;

    assign w_empty = (r_count == '0);

`ifdef PLAB4_NET_INPUT_QUEUE_BYPASS_EN
    assign w_bypass = w_empty && i_enq_val;
`else
    assign w_bypass = 1'b0;
`endif

    // No full-pass: a full queue refuses enq even while the head is leaving.
    assign o_enq_rdy  = (r_count != c_full);
    assign o_deq_val  = !w_empty || w_bypass;
    assign w_enq_fire = i_enq_val && o_enq_rdy;
    assign w_deq_fire = o_deq_val && i_deq_rdy;

    // A bypassed message that is consumed immediately never touches storage.
    assign w_wr_en  = w_enq_fire && !(w_bypass && i_deq_rdy);
    assign w_rd_adv = w_deq_fire && !w_bypass;

    always_comb begin
        // NOTE: default first so every path assigns w_count_next; no latch is inferred.
        w_count_next = r_count;
        if (w_wr_en && !w_rd_adv)
            w_count_next = r_count + 1'b1;
        else if (!w_wr_en && w_rd_adv)
            w_count_next = r_count - 1'b1;
    end

    // NOTE: state uses non-blocking assignments so all registers update from
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_num_free <= c_free_init;
        end else begin
            if (w_wr_en)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_adv)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count    <= w_count_next;
            r_num_free <= c_free_init - p_num_free_nbits'(w_count_next);
        end
    end

    assign o_wr_en      = w_wr_en;
    assign o_bypass_sel = w_bypass;
    assign o_wr_ptr     = r_wr_ptr;
    assign o_rd_ptr     = r_rd_ptr;
    assign o_num_free   = r_num_free;

endmodule

// File: rtl/plab4_net_router_input_queue.sv
// Ring-router per-port input queue: circular FIFO storage plus head/dest outputs.
// Optional same-cycle bypass when built with PLAB4_NET_INPUT_QUEUE_BYPASS_EN.
module plab4_net_router_input_queue
    import plab4_net_router_input_queue_pkg::*;
#(
    parameter  int p_msg_nbits      = c_net_msg_nbits,
    parameter  int p_num_entries    = 4,
    parameter  int p_num_routers    = c_net_num_routers,
    parameter  int p_num_free_nbits = 3,
    localparam int c_dest_nbits     = $clog2(p_num_routers),
    localparam int c_addr_nbits     = $clog2(p_num_entries)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enq_val,
    output logic                        enq_rdy,
    input  logic [p_msg_nbits-1:0]      enq_msg,
    output logic                        deq_val,
    input  logic                        deq_rdy,
    output logic [p_msg_nbits-1:0]      deq_msg,
    output logic [c_dest_nbits-1:0]     deq_dest,
    output logic [p_num_free_nbits-1:0] num_free
);

    logic                    w_wr_en;
    logic                    w_bypass_sel;
    logic [c_addr_nbits-1:0] w_wr_ptr;
    logic [c_addr_nbits-1:0] w_rd_ptr;

    logic [p_msg_nbits-1:0]  r_mem [p_num_entries];

    plab4_net_router_input_queue_ctrl #(
        .p_num_entries    (p_num_entries),
        .p_num_free_nbits (p_num_free_nbits),
        .c_addr_nbits     (c_addr_nbits)
    ) u_ctrl (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_enq_val    (enq_val),
        .i_deq_rdy    (deq_rdy),
        .o_enq_rdy    (enq_rdy),
        .o_deq_val    (deq_val),
        .o_wr_en      (w_wr_en),
        .o_bypass_sel (w_bypass_sel),
        .o_wr_ptr     (w_wr_ptr),
        .o_rd_ptr     (w_rd_ptr),
        .o_num_free   (num_free)
    );

    // NOTE: storage has no reset; occupancy is tracked by the pointers/count,
    // so stale entries are never presented as valid.
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[w_wr_ptr] <= enq_msg;
    end

    assign deq_msg  = w_bypass_sel ? enq_msg : r_mem[w_rd_ptr];
    assign deq_dest = `PLAB4_NET_DEST(deq_msg, c_dest_nbits);

endmodule
